led_pattern_sequencer: RTL and testbench

- Drives a bank of green board LEDs with a selectable animated pattern, replacing free-running counter-bit blinking.
- A programmable prescaler divides CLOCK_50 into a step tick; a run/pause/idle FSM gates the animation.
- A pattern engine advances one step per tick.
- Sits between the debounced board inputs (switches/keys, conditioned upstream) and LEDG.

---
 rtl/led_pattern_sequencer_if.sv | 22 ++
 rtl/led_pattern_sequencer.sv | 159 +++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/led_pattern_sequencer_if.sv
// Control/status bundle between the board-input conditioning and the LED sequencer.
interface led_pattern_sequencer_if #(
    parameter int N_LEDS = 8
);
    logic              start_stop;
    logic              clear;
    logic [1:0]        mode;
    logic [1:0]        rate;
    logic [N_LEDS-1:0] LEDG;
    logic              running;
    logic              tick;

    modport master (
        output start_stop, clear, mode, rate,
        input  LEDG, running, tick
    );

    modport slave (
        input  start_stop, clear, mode, rate,
        output LEDG, running, tick
    );
endinterface

// File: rtl/led_pattern_sequencer.sv
// Animated LED pattern sequencer: prescaled step tick, IDLE/RUN/PAUSE control,
// four pattern modes (blink, chase, bounce, binary count). All outputs registered.
module led_pattern_sequencer #(
    parameter int N_LEDS     = 8,
    parameter int PRESCALE_W = 20
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET,
    led_pattern_sequencer_if.slave  bus
);

    localparam int CNT_W = PRESCALE_W + 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        M_BLINK  = 2'd0,
        M_CHASE  = 2'd1,
        M_BOUNCE = 2'd2,
        M_COUNT  = 2'd3
    } mode_t;

    state_t            state_q;
    logic [N_LEDS-1:0] led_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              dir_up_q;
    logic [1:0]        mode_q;
    logic              running_q;
    logic              tick_q;

    logic [N_LEDS-1:0] init_pat;
    logic [N_LEDS-1:0] step_pat;
    logic              step_dir_up;
    logic [CNT_W-1:0]  tc;
    logic              mode_chg;

    // Terminal count for the selected rate; rate 3 wraps to all-ones in CNT_W bits.
    always_comb begin
        tc = (CNT_W'(1) << (PRESCALE_W + int'(rate_u()))) - CNT_W'(1);
    end

    function automatic logic [1:0] rate_u();
        return bus.rate;
    endfunction

    // Initial pattern of the currently selected mode (used on start and on mode change).
    always_comb begin
        init_pat = '0;
        case (mode_t'(bus.mode))
            M_BLINK:  init_pat = '1;
            M_CHASE:  init_pat = N_LEDS'(1);
            M_BOUNCE: init_pat = N_LEDS'(1);
            M_COUNT:  init_pat = '0;
            default:  init_pat = '0;
        endcase
    end

    // Next pattern and bounce direction for a tick edge, from the held pattern.
    always_comb begin
        step_pat    = led_q;
        step_dir_up = dir_up_q;
        case (mode_t'(mode_q))
            M_BLINK:  step_pat = ~led_q;
            M_CHASE:  step_pat = {led_q[N_LEDS-2:0], led_q[N_LEDS-1]};
            M_BOUNCE: begin
                if (dir_up_q) begin
                    step_pat    = led_q << 1;
                    step_dir_up = ~step_pat[N_LEDS-1];
                end else begin
                    step_pat    = led_q >> 1;
                    step_dir_up = step_pat[0];
                end
            end
            M_COUNT:  step_pat = led_q + N_LEDS'(1);
            default:  step_pat = led_q;
        endcase
    end

    assign mode_chg = (bus.mode != mode_q);

    // Control FSM with prescaler, pattern and direction registers; clear beats everything but RESET,
    // and a mode change in RUN/PAUSE reloads the pattern without changing state.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q   <= IDLE;
            led_q     <= '0;
            cnt_q     <= '0;
            dir_up_q  <= 1'b1;
            mode_q    <= '0;
            running_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            mode_q <= bus.mode;
            if (bus.clear) begin
                state_q   <= IDLE;
                led_q     <= '0;
                cnt_q     <= '0;
                dir_up_q  <= 1'b1;
                running_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        cnt_q <= '0;
                        if (bus.start_stop) begin
                            state_q   <= RUN;
                            led_q     <= init_pat;
                            dir_up_q  <= 1'b1;
                            running_q <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (mode_chg) begin
                            led_q    <= init_pat;
                            cnt_q    <= '0;
                            dir_up_q <= 1'b1;
                        end else if (bus.start_stop) begin
                            state_q   <= PAUSE;
                            running_q <= 1'b0;
                        end else if (cnt_q >= tc) begin
                            cnt_q    <= '0;
                            led_q    <= step_pat;
                            dir_up_q <= step_dir_up;
                            tick_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    PAUSE: begin
                        if (mode_chg) begin
                            led_q    <= init_pat;
                            cnt_q    <= '0;
                            dir_up_q <= 1'b1;
                        end else if (bus.start_stop) begin
                            state_q   <= RUN;
                            running_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q   <= IDLE;
                        led_q     <= '0;
                        cnt_q     <= '0;
                        dir_up_q  <= 1'b1;
                        running_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.LEDG    = led_q;
    assign bus.running = running_q;
    assign bus.tick    = tick_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with N_LEDS=4, PRESCALE_W=2.
module tb_led_pattern_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    led_pattern_sequencer_if #(.N_LEDS(4)) bus ();

    led_pattern_sequencer #(
        .N_LEDS    (4),
        .PRESCALE_W(2)
    ) dut (
        .CLOCK_50(clk),
        .RESET   (rst),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start_stop = 1'b1;
        step();
        bus.start_stop = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
    endtask

    task automatic wait_tick(input string tag, input int maxc, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.tick && n < maxc);
        if (!bus.tick) check({tag, "_timeout"}, 32'(bus.tick), 32'd1);
    endtask

    logic [3:0] exp_seq[$];
    int         n;
    logic       tick_seen;
    logic [4:0] v;

    initial begin
        bus.start_stop = 1'b0;
        bus.clear      = 1'b0;
        bus.mode       = 2'd0;
        bus.rate       = 2'd0;

        // Reset, then idle with no pulses
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_ledg", 32'(bus.LEDG), 32'h0);
        check("rst_run", 32'(bus.running), 32'd0);
        tick_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            tick_seen |= bus.tick;
        end
        check("idle_ledg", 32'(bus.LEDG), 32'h0);
        check("idle_run", 32'(bus.running), 32'd0);
        check("idle_tick", 32'(tick_seen), 32'd0);

        // Chase with wrap
        bus.mode = 2'd1;
        step();
        pulse_start();
        check("chase_init", 32'(bus.LEDG), 32'h1);
        check("chase_run", 32'(bus.running), 32'd1);
        check("chase_tick0", 32'(bus.tick), 32'd0);
        exp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        foreach (exp_seq[k]) begin
            wait_tick("chase", 10, n);
            check("chase_period", 32'(n), 32'd4);
            check("chase_ledg", 32'(bus.LEDG), 32'(exp_seq[k]));
        end
        step();
        check("chase_tick_1cyc", 32'(bus.tick), 32'd0);

        // Clear and start_stop together: clear wins
        bus.clear      = 1'b1;
        bus.start_stop = 1'b1;
        step();
        bus.clear      = 1'b0;
        bus.start_stop = 1'b0;
        check("clr_ledg", 32'(bus.LEDG), 32'h0);
        check("clr_run", 32'(bus.running), 32'd0);
        for (int i = 0; i < 10; i++) step();
        check("clr_idle_ledg", 32'(bus.LEDG), 32'h0);

        // Bounce at rate 1 (8 cycles per step)
        bus.mode = 2'd2;
        bus.rate = 2'd1;
        step();
        pulse_start();
        check("bnc_init", 32'(bus.LEDG), 32'h1);
        exp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        foreach (exp_seq[k]) begin
            wait_tick("bnc", 20, n);
            check("bnc_period", 32'(n), 32'd8);
            check("bnc_ledg", 32'(bus.LEDG), 32'(exp_seq[k]));
        end

        // Count with pause/resume and full wrap
        pulse_clear();
        bus.mode = 2'd3;
        bus.rate = 2'd0;
        step();
        pulse_start();
        check("cnt_init", 32'(bus.LEDG), 32'h0);
        for (int k = 1; k <= 3; k++) begin
            wait_tick("cnt", 10, n);
            check("cnt_period", 32'(n), 32'd4);
            check("cnt_ledg", 32'(bus.LEDG), 32'(k));
        end
        step();
        pulse_start();
        check("pause_run", 32'(bus.running), 32'd0);
        tick_seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            tick_seen |= bus.tick;
        end
        check("pause_ledg", 32'(bus.LEDG), 32'h3);
        check("pause_tick", 32'(tick_seen), 32'd0);
        pulse_start();
        check("resume_run", 32'(bus.running), 32'd1);
        wait_tick("resume", 8, n);
        check("resume_ledg", 32'(bus.LEDG), 32'h4);
        for (int k = 5; k <= 16; k++) begin
            v = 5'(k);
            wait_tick("cnt2", 10, n);
            check("cnt2_period", 32'(n), 32'd4);
            check("cnt2_ledg", 32'(bus.LEDG), 32'(v[3:0]));
        end

        // Rate decrease mid-period terminates on the next edge
        pulse_clear();
        bus.rate = 2'd1;
        step();
        pulse_start();
        for (int i = 0; i < 5; i++) step();
        bus.rate = 2'd0;
        step();
        check("rate_dec_tick", 32'(bus.tick), 32'd1);
        check("rate_dec_ledg", 32'(bus.LEDG), 32'h1);

        // Mode change mid-run, then RESET mid-run
        pulse_clear();
        bus.mode = 2'd1;
        step();
        pulse_start();
        check("mc_init", 32'(bus.LEDG), 32'h1);
        wait_tick("mc_a", 10, n);
        wait_tick("mc_b", 10, n);
        check("mc_at0100", 32'(bus.LEDG), 32'h4);
        step();
        bus.mode = 2'd0;
        step();
        check("mc_reload", 32'(bus.LEDG), 32'hF);
        check("mc_tick0", 32'(bus.tick), 32'd0);
        check("mc_run", 32'(bus.running), 32'd1);
        wait_tick("mc_blink", 10, n);
        check("mc_period", 32'(n), 32'd4);
        check("mc_toggle", 32'(bus.LEDG), 32'h0);
        step();
        step();
        rst = 1'b1;
        step();
        check("mrst_ledg", 32'(bus.LEDG), 32'h0);
        check("mrst_run", 32'(bus.running), 32'd0);
        check("mrst_tick", 32'(bus.tick), 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_run", 32'(bus.running), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
